// File: rtl/hrm_host_io.sv
// Host-side I/O bridge for the HRM CPU.
// Inbound: serial-rx bytes -> small staging FIFO -> CPU INBOX (honours cpu_in_full).
// Outbound: CPU OUTBOX -> serial tx, one byte in flight, start/busy handshake.
// Byte counters and a sticky overflow flag feed the debug display.
module hrm_host_io #(
  parameter int STG_LG = 2
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_overflow,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic [7:0] cpu_in_data,
  output logic       cpu_in_wr,
  input  logic       cpu_in_full,
  input  logic [7:0] cpu_out_data,
  input  logic       cpu_out_empty,
  output logic       cpu_out_rd,
  output logic [7:0] in_count,
  output logic [7:0] out_count
);

  localparam int DEPTH = 1 << STG_LG;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Inbound staging FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]        stg_mem [DEPTH];
  logic [STG_LG-1:0] rd_ptr;
  logic [STG_LG-1:0] wr_ptr;
  logic [STG_LG:0]   occ;
  logic              stg_full;
  logic              stg_empty;
  logic              push;
  logic              pop;

  // Occupancy never exceeds DEPTH = 2^STG_LG, so its MSB alone marks "full".
  assign stg_full    = occ[STG_LG];
  assign stg_empty   = (occ == '0);
  assign pop         = !stg_empty && !cpu_in_full;
  // A full FIFO still takes a byte when a pop frees a slot in the same cycle.
  assign push        = rx_valid && (!stg_full || pop);
  assign cpu_in_wr   = pop;
  assign cpu_in_data = stg_mem[rd_ptr];

  // Staging storage write.
  // NOTE: the data array is deliberately not reset; pointers and occupancy
  // define which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) stg_mem[wr_ptr] <= rx_data;
  end

  // Staging pointers, occupancy, inbound counter and sticky overflow.
  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occ         <= '0;
      rx_overflow <= 1'b0;
      in_count    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        in_count <= in_count + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (rx_valid && !push) rx_overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outbound FSM
  // ---------------------------------------------------------------------------
  state_t state;
  state_t state_nx;
  logic   launch;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; launch marks the IDLE -> WAIT_BUSY edge.
  // NOTE: defaults come first so every path assigns every output (no latches).
  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    case (state)
      IDLE: begin
        if (!cpu_out_empty && !tx_busy) begin
          launch   = 1'b1;
          state_nx = WAIT_BUSY;
        end
      end
      WAIT_BUSY: if (tx_busy)  state_nx = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Registered handshake pulses, held tx byte and outbound counter.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      tx_start   <= 1'b0;
      cpu_out_rd <= 1'b0;
      tx_data    <= '0;
      out_count  <= '0;
    end else begin
      tx_start   <= launch;
      cpu_out_rd <= launch;
      if (launch) begin
        tx_data   <= cpu_out_data;
        out_count <= out_count + 1'b1;
      end
    end
  end

endmodule

// File: doc/hrm_host_io.md
# hrm_host_io

Host-side I/O bridge for the HRM CPU: the other end of the CPU's INBOX write port and OUTBOX read port. It accepts a byte stream from a serial receiver (single-cycle strobes, no backpressure) and pushes the bytes into the CPU INBOX while honouring `cpu_in_full`. It also drains the CPU OUTBOX one byte at a time into a serial transmitter using a start/busy handshake. It sits in the board top between the UART rx/tx blocks and `hrmcpu`, and keeps byte counters and a sticky overflow flag for the debug display.

## Interface
Parameters:
- `STG_LG`, default 2: log2 of inbound staging FIFO depth (depth 4).

Ports:
- `clk` in 1: system clock. One clock domain; all logic on rising edge.
- `i_rst` in 1: reset, synchronous, active-high.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `rx_overflow` out 1: sticky; set when a byte is dropped because staging is full.
- `tx_data` out 8: byte to transmit; held stable from `tx_start` until the FSM returns to IDLE.
- `tx_start` out 1: one-cycle pulse requesting transmission of `tx_data`.
- `tx_busy` in 1: transmitter busy; rises at least one cycle after `tx_start`.
- `cpu_in_data` out 8: byte to CPU INBOX.
- `cpu_in_wr` out 1: INBOX write strobe.
- `cpu_in_full` in 1: INBOX full.
- `cpu_out_data` in 8: OUTBOX head byte. First-word fall-through: valid whenever `cpu_out_empty` = 0.
- `cpu_out_empty` in 1: OUTBOX empty.
- `cpu_out_rd` out 1: OUTBOX pop strobe.
- `in_count` out 8: bytes written to INBOX. Wraps 255→0.
- `out_count` out 8: bytes popped from OUTBOX. Wraps 255→0.

## Operation
Inbound path:
- Staging is a circular FIFO of 2^STG_LG entries with read/write pointers and an occupancy count of width STG_LG+1.
- Push when `rx_valid` is high and staging is not full.
- `rx_valid` while staging is full: the byte is dropped and `rx_overflow` is set to 1. Exception: if a pop occurs in the same cycle, the push is accepted and no overflow is flagged.
- `cpu_in_wr` = staging not empty AND NOT `cpu_in_full`. This is combinational from registered occupancy and the input flag.
- `cpu_in_data` = staging head.
- A pop occurs in any cycle where `cpu_in_wr` = 1. `in_count` increments in the same cycle.
- Push and pop in the same cycle: occupancy is unchanged and both pointers advance.

Outbound FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE → WAIT_BUSY when `cpu_out_empty` = 0 and `tx_busy` = 0. On that edge:
  - `tx_data` ← `cpu_out_data`.
  - `cpu_out_rd` ← 1 and `tx_start` ← 1, both for one cycle.
  - `out_count` += 1.
- WAIT_BUSY → WAIT_DONE when `tx_busy` = 1.
- WAIT_DONE → IDLE when `tx_busy` = 0.
- `cpu_out_rd` and `tx_start` are never high in two consecutive cycles. At most one byte is in flight at a time.

Reset (`i_rst` = 1 at any edge, including mid-operation):
- Staging is flushed, FSM returns to IDLE, all counters clear, and `rx_overflow` clears.
- A byte already popped from OUTBOX but not yet sent is lost.
- A `rx_valid` in the reset cycle is ignored.

## Timing
- Reset values: `tx_start` = 0, `cpu_out_rd` = 0, `tx_data` = 0x00, `rx_overflow` = 0, `in_count` = 0, `out_count` = 0. `cpu_in_wr` = 0 (staging is empty), `cpu_in_data` = don't-care.
- Inbound latency: with `rx_valid` in cycle N, staging empty and INBOX not full, `cpu_in_wr` = 1 in cycle N+1 with that byte on `cpu_in_data`.
- Sustained inbound throughput is one byte per cycle while INBOX is not full.
- Outbound latency: if `cpu_out_empty` falls in cycle N while IDLE and `tx_busy` = 0, then `tx_start`/`cpu_out_rd` are high in cycle N+1.
- Minimum outbound spacing: the next `tx_start` comes no earlier than one cycle after `tx_busy` falls.
- When `cpu_in_full` is high, `cpu_in_wr` is 0 in that same cycle.

## Test plan
- Reset, then check all outputs: `tx_start` = 0, `cpu_out_rd` = 0, `tx_data` = 0x00, `rx_overflow` = 0, `in_count` = 0, `out_count` = 0, `cpu_in_wr` = 0.
- Strobe 0x05 then 0x7F on consecutive cycles with INBOX not full → `cpu_in_wr` high in the next two cycles with data 0x05 then 0x7F; `in_count` = 2.
- Hold `cpu_in_full` = 1 and strobe 6 bytes 0x10..0x15 → first 4 are staged and `rx_overflow` = 1. Release full → exactly 0x10..0x13 are written in order; `in_count` = 4; `rx_overflow` stays 1 until reset.
- Staging full, `cpu_in_full` = 0, `rx_valid` with 0xAA → accepted with no overflow; 0xAA is written after the 3 older bytes.
- Model an OUTBOX holding 0x01, 0xFE with `tx_busy` modeled as 3 cycles high after a 1-cycle delay:
  - Exactly two `tx_start` pulses, with `tx_data` 0x01 then 0xFE.
  - `cpu_out_rd` coincides with each `tx_start`.
  - No second start before `tx_busy` falls.
  - `out_count` = 2.
- Assert `i_rst` in WAIT_DONE with 2 bytes staged → next cycle the FSM is IDLE, `cpu_in_wr` = 0, counters = 0, and no `tx_start` occurs until `cpu_out_empty` = 0 and `tx_busy` = 0.
